// File: rtl/milano_mem_arbiter.sv
// Shares one system-bus memory port between the milano fetch (instr) and load/store (data) ports.
// Holds a stalled request until granted and returns in-order responses to their owners.
module milano_mem_arbiter #(
  parameter int MAX_OUTST  = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rsp_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int STV_W = $clog2(STARVE_LIM + 1);

  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t               state_r;
  logic                 owner_r;
  logic [MAX_OUTST-1:0] fifo_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [STV_W-1:0]     starve_r;
  logic                 err_r;

  logic mem_req_s;
  logic sel_s;
  logic push_s;
  logic pop_s;
  logic head_s;
  logic full_s;
  logic starved_s;
  logic instr_gnt_s;
  logic data_gnt_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(MAX_OUTST - 1)) begin
      ptr_next = {PTR_W{1'b0}};
    end else begin
      ptr_next = ptr + PTR_W'(1);
    end
  endfunction

  assign full_s    = (count_r == CNT_W'(MAX_OUTST));
  assign starved_s = (starve_r == STV_W'(STARVE_LIM));
  assign head_s    = fifo_r[rd_ptr_r];

  // Request arbitration: a held request keeps its owner, otherwise data wins unless instr is starved.
  always_comb begin
    mem_req_s = 1'b0;
    sel_s     = OWN_INSTR;
    if (rst_i) begin
      mem_req_s = 1'b0;
      sel_s     = OWN_INSTR;
    end else if (state_r == ST_HOLD) begin
      mem_req_s = 1'b1;
      sel_s     = owner_r;
    end else if (!full_s && (instr_req_i || data_req_i)) begin
      mem_req_s = 1'b1;
      sel_s     = (data_req_i && !(instr_req_i && starved_s)) ? OWN_DATA : OWN_INSTR;
    end else begin
      mem_req_s = 1'b0;
      sel_s     = OWN_INSTR;
    end
  end

  assign push_s      = mem_req_s & mem_gnt_i;
  assign instr_gnt_s = push_s & (sel_s == OWN_INSTR);
  assign data_gnt_s  = push_s & (sel_s == OWN_DATA);
  assign pop_s       = mem_rvalid_i & (count_r != CNT_W'(0));

  assign instr_gnt_o    = instr_gnt_s;
  assign data_gnt_o     = data_gnt_s;
  assign mem_req_o      = mem_req_s;
  assign instr_rvalid_o = pop_s & (head_s == OWN_INSTR);
  assign data_rvalid_o  = pop_s & (head_s == OWN_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0000_0000;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0000_0000;
  assign rsp_err_o      = err_r;

  // Bus request field mux; fetches are always full-word reads.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0000_0000;
    mem_wdata_o = 32'h0000_0000;
    if (mem_req_s && (sel_s == OWN_DATA)) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else if (mem_req_s) begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_addr_o  = instr_addr_i;
      mem_wdata_o = 32'h0000_0000;
    end else begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0000_0000;
      mem_wdata_o = 32'h0000_0000;
    end
  end

  // Request FSM: latch the owner when the bus stalls so the request cannot change mid-handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_INSTR;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_req_s && !mem_gnt_i) begin
            state_r <= ST_HOLD;
            owner_r <= sel_s;
          end
        end
        ST_HOLD: begin
          if (mem_gnt_i) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          owner_r <= OWN_INSTR;
        end
      endcase
    end
  end

  // Owner FIFO: one entry per granted request, popped by each in-order response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_r   <= {MAX_OUTST{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= sel_s;
        wr_ptr_r         <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter: counts data grants that bypassed a waiting fetch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_r <= {STV_W{1'b0}};
    end else if (!instr_req_i || instr_gnt_s) begin
      starve_r <= {STV_W{1'b0}};
    end else if (data_gnt_s && !starved_s) begin
      starve_r <= starve_r + STV_W'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

  // Sticky flag for a response that has no matching outstanding request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (mem_rvalid_i && (count_r == CNT_W'(0))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule
